// File: rtl/image_dispatcher_if.sv
// Pixel ingress and prediction egress handshakes of the image dispatcher.
// master = upstream/downstream environment, slave = dispatcher.
interface image_dispatcher_if #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 32
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [DATA_WIDTH-1:0] pix_data;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [OUT_WIDTH-1:0]  pred_data;
    logic [IW-1:0]         pred_core;
    logic                  pred_valid;
    logic                  pred_ready;

    modport master (
        output pix_data, pix_valid, pred_ready,
        input  pix_ready, pred_data, pred_core, pred_valid
    );

    modport slave (
        input  pix_data, pix_valid, pred_ready,
        output pix_ready, pred_data, pred_core, pred_valid
    );
endinterface

// File: rtl/image_dispatcher.sv
// Batches N images into a flat buffer, launches the core array, drains predictions.
// Optional WAIT watchdog enabled by defining DISPATCH_TIMEOUT_EN.
module image_dispatcher #(
    parameter int N              = 4,
    parameter int IMG_SIZE       = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int OUT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    image_dispatcher_if.slave              io,
    output logic [N*IMG_SIZE*DATA_WIDTH-1:0] images_out,
    output logic                           core_start,
    input  logic                           core_done,
    input  logic [N*OUT_WIDTH-1:0]         core_preds,
    output logic                           busy,
    output logic                           timeout_err
);
    localparam int WORDS = N * IMG_SIZE;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int IW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] LAST_W = AW'(WORDS - 1);
    localparam logic [IW-1:0] LAST_C = IW'(N - 1);

    typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;

    state_t                state;
    logic [AW-1:0]         wr_idx;
    logic [IW-1:0]         rd_idx;
    logic [IW-1:0]         rd_nxt;
    logic [DATA_WIDTH-1:0] buf_q [WORDS];
    logic [OUT_WIDTH-1:0]  cap_q [N];

`ifdef DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    assign rd_nxt       = rd_idx + IW'(1);
    assign busy         = (state != LOAD);
    assign io.pix_ready = (state == LOAD);

    // wr_idx walks core-major, so flat word index equals core*IMG_SIZE+word
    always_comb begin
        images_out = '0;
        for (int i = 0; i < WORDS; i++)
            images_out[i*DATA_WIDTH +: DATA_WIDTH] = buf_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= LOAD;
            wr_idx        <= '0;
            rd_idx        <= '0;
            core_start    <= 1'b0;
            io.pred_valid <= 1'b0;
            io.pred_data  <= '0;
            io.pred_core  <= '0;
            for (int i = 0; i < WORDS; i++)
                buf_q[i] <= '0;
            for (int c = 0; c < N; c++)
                cap_q[c] <= '0;
`ifdef DISPATCH_TIMEOUT_EN
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            core_start <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (io.pix_valid) begin
                        buf_q[wr_idx] <= io.pix_data;
                        if (wr_idx == LAST_W) begin
                            wr_idx     <= '0;
                            core_start <= 1'b1;
                            state      <= START;
                        end else begin
                            wr_idx <= wr_idx + AW'(1);
                        end
                    end
                end
                START: begin
                    state <= WAIT;
`ifdef DISPATCH_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                WAIT: begin
                    // done on the watchdog's last cycle still wins
                    if (core_done) begin
                        for (int c = 0; c < N; c++)
                            cap_q[c] <= core_preds[c*OUT_WIDTH +: OUT_WIDTH];
                        io.pred_data  <= core_preds[0 +: OUT_WIDTH];
                        io.pred_core  <= '0;
                        io.pred_valid <= 1'b1;
                        rd_idx        <= '0;
                        state         <= DRAIN;
                    end
`ifdef DISPATCH_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= LOAD;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
`endif
                end
                DRAIN: begin
                    if (io.pred_ready) begin
                        if (rd_idx == LAST_C) begin
                            io.pred_valid <= 1'b0;
                            rd_idx        <= '0;
                            state         <= LOAD;
                        end else begin
                            rd_idx       <= rd_nxt;
                            io.pred_data <= cap_q[rd_nxt];
                            io.pred_core <= rd_nxt;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule
